// File: rtl/scram23_pkg.sv
// Shared definitions for the 23-bit multi-lane 128b/130b scrambler:
// LFSR polynomial and per-lane seeds, sync-header and OS symbol codes,
// block classification and the unrolled LFSR/XOR step.
package scram23_pkg;

  // Galois feedback mask for x^23+x^21+x^16+x^8+x^5+x^2+1.
  // The x^23 term is the bit shifted out of position 22.
  localparam logic [22:0] LFSR_TAPS = 23'h210125;

  // Lane n starts from SEED[n mod 8].
  localparam logic [22:0] SEED [0:7] = '{
    23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
    23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
  };

  // Sync headers as they arrive alongside in_sob.
  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;

  // Lane-0 symbol-0 codes that identify special ordered sets.
  localparam logic [7:0] SKP_SYM   = 8'hAA;
  localparam logic [7:0] EIEOS_SYM = 8'h00;

  // Block type latched at the start of each block.
  typedef enum logic [1:0] {
    BLK_DATA,
    BLK_OS,
    BLK_SKP,
    BLK_EIEOS
  } blk_type_e;

  // Block tracker states.
  typedef enum logic {
    TRK_UNALIGNED,
    TRK_IN_BLOCK
  } trk_state_e;

  // Result of advancing one lane's LFSR over a beat.
  typedef struct packed {
    logic [22:0] state;
    logic [31:0] data;
  } lfsr_res_t;

  // Advance the LFSR n times, XORing each key bit (lfsr[22], taken before
  // the shift) into data bit i. Bit 0 goes first on the wire, so it meets
  // the earliest key bit. Bits at and above n are returned untouched.
  function automatic lfsr_res_t lfsr_step_n(input logic [22:0] state,
                                            input logic [31:0] data,
                                            input int          n);
    lfsr_res_t res;
    logic      key;
    res.state = state;
    res.data  = data;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        key         = res.state[22];
        res.data[i] = data[i] ^ key;
        res.state   = {res.state[21:0], 1'b0} ^ ({23{key}} & LFSR_TAPS);
      end
    end
    return res;
  endfunction

  // Classify a block from its sync header and lane-0 symbol 0.
  // Anything that is not a clean data header is handled as an OS block,
  // including the illegal headers 00 and 11.
  function automatic blk_type_e blk_classify(input logic [1:0] sync,
                                             input logic [7:0] sym0);
    blk_type_e t;
    if (sync == SYNC_DATA) begin
      t = BLK_DATA;
    end else if (sync == SYNC_OS && sym0 == SKP_SYM) begin
      t = BLK_SKP;
    end else if (sync == SYNC_OS && sym0 == EIEOS_SYM) begin
      t = BLK_EIEOS;
    end else begin
      t = BLK_OS;
    end
    return t;
  endfunction

endpackage

// File: rtl/scram23_lane.sv
// One lane of the scrambler: a 23-bit Galois LFSR plus the output XOR and
// the lane's output register. The shared block tracker in the top decides,
// per beat, whether this lane scrambles, advances, or reloads its seed.
module scram23_lane
  import scram23_pkg::*;
#(
  parameter int          DW   = 8,
  parameter logic [22:0] SEED = 23'h1DBFBC
) (
  input  logic          clk_1G,
  input  logic          rst_1G,
  input  logic          beat_valid,
  input  logic          scram,
  input  logic          advance,
  input  logic          load_seed,
  input  logic [DW-1:0] lane_in,
  output logic [DW-1:0] lane_out
);

  logic [22:0]   lfsr_q, lfsr_d;
  logic [DW-1:0] out_q, out_d;
  lfsr_res_t     step;
  logic          step_unused;

  // Only the low DW bits of the step result carry lane data.
  assign step_unused = ^step.data;

  // Compute the beat's keystream and decide next LFSR state and output;
  // a reseed wins over an advance, and idle cycles hold everything.
  always_comb begin
    step   = lfsr_step_n(lfsr_q, 32'(lane_in), DW);
    lfsr_d = lfsr_q;
    out_d  = out_q;
    if (beat_valid) begin
      out_d = scram ? step.data[DW-1:0] : lane_in;
      if (load_seed) begin
        lfsr_d = SEED;
      end else if (advance) begin
        lfsr_d = step.state;
      end
    end
  end

  // LFSR and output register; reset restores the seed and clears the output.
  always_ff @(posedge clk_1G) begin
    if (rst_1G) begin
      lfsr_q <= SEED;
      out_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      out_q  <= out_d;
    end
  end

  assign lane_out = out_q;

endmodule

// File: rtl/scrambler_23b_mlane.sv
// Multi-lane 128b/130b scrambler. A single block tracker follows the
// 16-symbol block framing, latches block type and scrambling mode at each
// in_sob, and steers every lane's LFSR/XOR. All outputs are registered, so
// a beat accepted on one rising edge is visible after the next.
module scrambler_23b_mlane
  import scram23_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW    = 8
) (
  input  logic                clk_1G,
  input  logic                rst_1G,
  input  logic [1:0]          en_scram,
  input  logic                in_valid,
  input  logic                in_sob,
  input  logic [1:0]          in_sync,
  input  logic [LANES*DW-1:0] in_data,
  output logic                out_valid,
  output logic                out_sob,
  output logic [1:0]          out_sync,
  output logic [LANES*DW-1:0] out_data,
  output logic                align_err
);

  // Symbols per lane per beat.
  localparam int SPC = DW / 8;

  trk_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  blk_type_e  btype_q, btype_d;
  logic [1:0] mode_q, mode_d;

  logic       out_valid_q, out_valid_d;
  logic       out_sob_q, out_sob_d;
  logic [1:0] out_sync_q, out_sync_d;
  logic       align_err_q, align_err_d;

  // Per-beat view of the block: type/mode/start symbol that govern this beat.
  blk_type_e  eff_type;
  logic [1:0] eff_mode;
  logic [3:0] base;
  logic       active;
  logic       last_beat;

  // Lane controls shared by all lanes.
  logic       scram;
  logic       advance;
  logic       load_seed;

  // Block tracker: start blocks on in_sob, count symbols, flag framing
  // errors, and register the sideband outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    btype_d     = btype_q;
    mode_d      = mode_q;
    align_err_d = 1'b0;
    eff_type    = btype_q;
    eff_mode    = mode_q;
    base        = cnt_q;
    active      = 1'b0;
    out_valid_d = in_valid;
    out_sob_d   = in_sob;
    out_sync_d  = in_sync;

    if (in_valid) begin
      if (in_sob) begin
        // A new block always restarts here; an early in_sob aborts the old one.
        align_err_d = (state_q == TRK_IN_BLOCK) && (cnt_q != 4'd0);
        eff_type    = blk_classify(in_sync, in_data[7:0]);
        eff_mode    = en_scram;
        btype_d     = eff_type;
        mode_d      = en_scram;
        base        = 4'd0;
        active      = 1'b1;
        state_d     = TRK_IN_BLOCK;
        cnt_d       = 4'(SPC);
      end else if (state_q == TRK_IN_BLOCK) begin
        if (cnt_q == 4'd0) begin
          // Block boundary reached but no in_sob: lose alignment.
          align_err_d = 1'b1;
          state_d     = TRK_UNALIGNED;
        end else begin
          active = 1'b1;
          cnt_d  = cnt_q + 4'(SPC);
        end
      end
    end

    last_beat = ({1'b0, base} + 5'(SPC)) == 5'd16;
  end

  // Translate block type and mode into per-beat lane controls.
  always_comb begin
    scram     = 1'b0;
    advance   = 1'b0;
    load_seed = 1'b0;
    if (active) begin
      if (!eff_mode[0]) begin
        // Bypass keeps every LFSR parked on its seed.
        load_seed = 1'b1;
      end else begin
        if (eff_mode[1]) begin
          scram   = 1'b1;
          advance = 1'b1;
        end else begin
          case (eff_type)
            BLK_DATA: begin
              scram   = 1'b1;
              advance = 1'b1;
            end
            BLK_OS:    advance = 1'b1;
            BLK_SKP:   advance = 1'b0;
            BLK_EIEOS: advance = 1'b1;
            default:   advance = 1'b0;
          endcase
        end
        if (eff_type == BLK_EIEOS && last_beat) begin
          load_seed = 1'b1;
        end
      end
    end
  end

  // Tracker and sideband registers; reset drops any block in progress.
  always_ff @(posedge clk_1G) begin
    if (rst_1G) begin
      state_q     <= TRK_UNALIGNED;
      cnt_q       <= 4'd0;
      btype_q     <= BLK_OS;
      mode_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_sob_q   <= 1'b0;
      out_sync_q  <= 2'b00;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btype_q     <= btype_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_sob_q   <= out_sob_d;
      out_sync_q  <= out_sync_d;
      align_err_q <= align_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sob   = out_sob_q;
  assign out_sync  = out_sync_q;
  assign align_err = align_err_q;

  // One LFSR/XOR lane per lane, seeds cycling through the 8-entry table.
  for (genvar n = 0; n < LANES; n++) begin : g_lane
    scram23_lane #(
      .DW   (DW),
      .SEED (SEED[n % 8])
    ) u_lane (
      .clk_1G     (clk_1G),
      .rst_1G     (rst_1G),
      .beat_valid (in_valid),
      .scram      (scram),
      .advance    (advance),
      .load_seed  (load_seed),
      .lane_in    (in_data[n*DW +: DW]),
      .lane_out   (out_data[n*DW +: DW])
    );
  end

endmodule

// File: tb/tb_scrambler_23b_mlane.sv
// Bench for scrambler_23b_mlane: a 4-lane x 8-bit instance driven from
// vector tables and hand sequences, plus a 9-lane x 32-bit instance.
// Expected keystreams come from an independent reference LFSR below.
module tb_scrambler_23b_mlane;

  localparam logic [22:0] SEEDS [0:7] = '{
    23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
    23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
  };

  logic clk_1G = 1'b0;
  logic rst_1G;

  always #5 clk_1G = ~clk_1G;

  logic [1:0]   a_en, a_sync, a_out_sync;
  logic         a_valid, a_sob, a_out_valid, a_out_sob, a_align_err;
  logic [31:0]  a_data, a_out_data;

  logic [1:0]   b_en, b_sync, b_out_sync;
  logic         b_valid, b_sob, b_out_valid, b_out_sob, b_align_err;
  logic [287:0] b_data, b_out_data;

  scrambler_23b_mlane #(.LANES(4), .DW(8)) dut_a (
    .clk_1G    (clk_1G),
    .rst_1G    (rst_1G),
    .en_scram  (a_en),
    .in_valid  (a_valid),
    .in_sob    (a_sob),
    .in_sync   (a_sync),
    .in_data   (a_data),
    .out_valid (a_out_valid),
    .out_sob   (a_out_sob),
    .out_sync  (a_out_sync),
    .out_data  (a_out_data),
    .align_err (a_align_err)
  );

  scrambler_23b_mlane #(.LANES(9), .DW(32)) dut_b (
    .clk_1G    (clk_1G),
    .rst_1G    (rst_1G),
    .en_scram  (b_en),
    .in_valid  (b_valid),
    .in_sob    (b_sob),
    .in_sync   (b_sync),
    .in_data   (b_data),
    .out_valid (b_out_valid),
    .out_sob   (b_out_sob),
    .out_sync  (b_out_sync),
    .out_data  (b_out_data),
    .align_err (b_align_err)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic        sob;
    logic [1:0]  sync;
    logic [1:0]  en;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  // Reference LFSR: explicit per-bit Galois update for the PCIe polynomial.
  function automatic logic [22:0] ref_step(input logic [22:0] s);
    logic [22:0] r;
    logic        fb;
    fb   = s[22];
    r[0] = fb;
    for (int i = 1; i < 23; i++) r[i] = s[i-1];
    r[2]  = r[2]  ^ fb;
    r[5]  = r[5]  ^ fb;
    r[8]  = r[8]  ^ fb;
    r[16] = r[16] ^ fb;
    r[21] = r[21] ^ fb;
    return r;
  endfunction

  // Keystream bits [offset, offset+width) of a lane started from seed.
  function automatic logic [31:0] ks(input logic [22:0] seed, input int offset, input int width);
    logic [22:0] s;
    logic [31:0] r;
    s = seed;
    r = '0;
    for (int i = 0; i < offset + width; i++) begin
      if (i >= offset) r[i-offset] = s[22];
      s = ref_step(s);
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_a(input logic [31:0] d, input bit scr, input int off);
    logic [31:0] r;
    logic [31:0] k;
    r = d;
    if (scr) begin
      for (int n = 0; n < 4; n++) begin
        k = ks(SEEDS[n], off, 8);
        r[n*8 +: 8] = d[n*8 +: 8] ^ k[7:0];
      end
    end
    return r;
  endfunction

  function automatic logic [287:0] exp_b(input logic [287:0] d, input bit scr, input int off);
    logic [287:0] r;
    r = d;
    if (scr) begin
      for (int n = 0; n < 9; n++) r[n*32 +: 32] = d[n*32 +: 32] ^ ks(SEEDS[n % 8], off, 32);
    end
    return r;
  endfunction

  function automatic logic [287:0] rand288();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check_output(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus_a(input logic v, input logic sob, input logic [1:0] sync,
                                  input logic [1:0] en, input logic [31:0] d);
    a_valid = v;
    a_sob   = sob;
    a_sync  = sync;
    a_en    = en;
    a_data  = d;
    @(posedge clk_1G);
    #1;
  endtask

  task automatic apply_stimulus_b(input logic v, input logic sob, input logic [1:0] sync,
                                  input logic [1:0] en, input logic [287:0] d);
    b_valid = v;
    b_sob   = sob;
    b_sync  = sync;
    b_en    = en;
    b_data  = d;
    @(posedge clk_1G);
    #1;
  endtask

  // Queue one block (or its first nbeats beats) for the 4x8 instance.
  task automatic add_block(input logic [1:0] sync, input logic [1:0] en, input int sym0,
                           input bit rnd, input bit scr, input int off, input int nbeats);
    vec_t v;
    for (int b = 0; b < nbeats; b++) begin
      v.sob  = (b == 0);
      v.sync = sync;
      v.en   = en;
      v.data = rnd ? $urandom() : 32'h0;
      if (b == 0 && sym0 >= 0) v.data[7:0] = 8'(sym0);
      v.exp_data = exp_a(v.data, scr, off + 8*b);
      v.exp_err  = 1'b0;
      tbl.push_back(v);
    end
  endtask

  // Queue a beat without in_sob that must pass through unscrambled.
  task automatic add_loose(input logic err);
    vec_t v;
    v.sob      = 1'b0;
    v.sync     = 2'b10;
    v.en       = 2'b01;
    v.data     = $urandom();
    v.exp_data = v.data;
    v.exp_err  = err;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      apply_stimulus_a(1'b1, tbl[i].sob, tbl[i].sync, tbl[i].en, tbl[i].data);
      check_output($sformatf("%s[%0d].valid", tag, i), 288'(a_out_valid), 288'(1'b1));
      check_output($sformatf("%s[%0d].sob", tag, i), 288'(a_out_sob), 288'(tbl[i].sob));
      check_output($sformatf("%s[%0d].sync", tag, i), 288'(a_out_sync), 288'(tbl[i].sync));
      check_output($sformatf("%s[%0d].err", tag, i), 288'(a_align_err), 288'(tbl[i].exp_err));
      check_output($sformatf("%s[%0d].data", tag, i), 288'(a_out_data), 288'(tbl[i].exp_data));
    end
    tbl.delete();
  endtask

  initial begin
    logic [31:0]  d, prev;
    logic [287:0] bd;
    int           idx;

    // Reset with busy inputs: nothing may leak through.
    rst_1G = 1'b1;
    a_valid = 1'b1; a_sob = 1'b1; a_sync = 2'b10; a_en = 2'b01; a_data = 32'hFFFF_FFFF;
    b_valid = 1'b1; b_sob = 1'b1; b_sync = 2'b10; b_en = 2'b01; b_data = '1;
    repeat (2) @(posedge clk_1G);
    #1;
    check_output("rst_a.valid", 288'(a_out_valid), 288'(0));
    check_output("rst_a.sob", 288'(a_out_sob), 288'(0));
    check_output("rst_a.sync", 288'(a_out_sync), 288'(0));
    check_output("rst_a.err", 288'(a_align_err), 288'(0));
    check_output("rst_a.data", 288'(a_out_data), 288'(0));
    check_output("rst_b.valid", 288'(b_out_valid), 288'(0));
    check_output("rst_b.data", b_out_data, 288'(0));
    rst_1G  = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge clk_1G);
    #1;

    // Unaligned after reset: clear passthrough, no error.
    add_loose(1'b0);
    add_loose(1'b0);
    run_table("unaligned");

    // Mode 01 data block of zeros: raw keystream from each seed.
    add_block(2'b10, 2'b01, -1, 1'b0, 1'b1, 0, 16);
    run_table("zero_blk");

    // Data, SKP (clear, LFSR frozen), data resuming at bit 256.
    add_block(2'b10, 2'b01, -1, 1'b1, 1'b1, 128, 16);
    add_block(2'b01, 2'b01, 8'hAA, 1'b1, 1'b0, 0, 16);
    add_block(2'b10, 2'b01, -1, 1'b1, 1'b1, 256, 16);
    run_table("skp");

    // EIEOS (clear, advances, reseeds at its end), then zeros from the seed.
    add_block(2'b01, 2'b01, 8'h00, 1'b1, 1'b0, 0, 16);
    add_block(2'b10, 2'b01, -1, 1'b0, 1'b1, 0, 16);
    run_table("eieos");

    // Bypass blocks (00 and 10), then mode 01 starts from the seed.
    add_block(2'b10, 2'b00, -1, 1'b1, 1'b0, 0, 16);
    add_block(2'b01, 2'b10, 8'h55, 1'b1, 1'b0, 0, 16);
    add_block(2'b10, 2'b01, -1, 1'b0, 1'b1, 0, 16);
    run_table("bypass");

    // Early in_sob at counter 7, then a block boundary without in_sob.
    add_block(2'b10, 2'b01, -1, 1'b1, 1'b1, 128, 7);
    idx = tbl.size();
    add_block(2'b10, 2'b01, -1, 1'b1, 1'b1, 184, 16);
    tbl[idx].exp_err = 1'b1;
    add_loose(1'b1);
    add_loose(1'b0);
    run_table("align");

    // Data block with idle gaps of 1..3 cycles; output must match gapless.
    prev = '0;
    for (int b = 0; b < 16; b++) begin
      d = $urandom();
      apply_stimulus_a(1'b1, b == 0, 2'b10, 2'b01, d);
      prev = exp_a(d, 1'b1, 312 + 8*b);
      check_output($sformatf("gap_beat[%0d].data", b), 288'(a_out_data), 288'(prev));
      check_output($sformatf("gap_beat[%0d].err", b), 288'(a_align_err), 288'(0));
      if (b == 3 || b == 8 || b == 13) begin
        for (int g = 0; g < (b % 3) + 1; g++) begin
          apply_stimulus_a(1'b0, 1'b1, 2'b01, 2'b11, $urandom());
          check_output($sformatf("gap_idle[%0d.%0d].valid", b, g), 288'(a_out_valid), 288'(0));
          check_output($sformatf("gap_idle[%0d.%0d].data", b, g), 288'(a_out_data), 288'(prev));
          check_output($sformatf("gap_idle[%0d.%0d].err", b, g), 288'(a_align_err), 288'(0));
        end
      end
    end

    // Mode 11 scrambles SKP; OS and invalid-header blocks advance in clear.
    add_block(2'b01, 2'b11, 8'hAA, 1'b1, 1'b1, 440, 16);
    add_block(2'b01, 2'b01, 8'h1E, 1'b1, 1'b0, 0, 16);
    add_block(2'b00, 2'b01, 8'hAA, 1'b1, 1'b0, 0, 16);
    add_block(2'b10, 2'b01, -1, 1'b1, 1'b1, 824, 16);
    run_table("diag_os");

    a_valid = 1'b0;

    // 9 lanes x 32 bits: 4 beats per block, lane 8 reuses lane 0's seed.
    rst_1G = 1'b1;
    @(posedge clk_1G);
    #1;
    rst_1G = 1'b0;
    for (int b = 0; b < 4; b++) begin
      apply_stimulus_b(1'b1, b == 0, 2'b10, 2'b01, '0);
      check_output($sformatf("wide_zero[%0d].data", b), b_out_data, exp_b('0, 1'b1, 32*b));
      check_output($sformatf("wide_zero[%0d].err", b), 288'(b_align_err), 288'(0));
    end
    for (int b = 0; b < 2; b++) begin
      bd = rand288();
      apply_stimulus_b(1'b1, b == 0, 2'b10, 2'b01, bd);
      check_output($sformatf("wide_pre[%0d].data", b), b_out_data, exp_b(bd, 1'b1, 128 + 32*b));
    end
    rst_1G = 1'b1;
    apply_stimulus_b(1'b1, 1'b0, 2'b10, 2'b01, rand288());
    check_output("wide_rst.valid", 288'(b_out_valid), 288'(0));
    check_output("wide_rst.sob", 288'(b_out_sob), 288'(0));
    check_output("wide_rst.err", 288'(b_align_err), 288'(0));
    check_output("wide_rst.data", b_out_data, 288'(0));
    rst_1G = 1'b0;
    bd = rand288();
    apply_stimulus_b(1'b1, 1'b0, 2'b10, 2'b01, bd);
    check_output("wide_unal.data", b_out_data, bd);
    check_output("wide_unal.err", 288'(b_align_err), 288'(0));
    for (int b = 0; b < 4; b++) begin
      apply_stimulus_b(1'b1, b == 0, 2'b10, 2'b01, '0);
      check_output($sformatf("wide_seed[%0d].data", b), b_out_data, exp_b('0, 1'b1, 32*b));
      check_output($sformatf("wide_seed[%0d].sync", b), 288'(b_out_sync), 288'(2'b10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/scrambler_23b_mlane.md
# scrambler_23b_mlane

Multi-lane, width-parametrised 128b/130b scrambler using the 23-bit PCIe Gen3 LFSR with per-lane seeds and block-type awareness.
- Data blocks are scrambled; ordered-set (OS) blocks pass through clear.
- SKP blocks freeze the LFSR; EIEOS blocks reseed it.
- Sits between the per-lane DLL byte stream and the 130b sync-header inserter, on a single clock.

## Interface
Parameters:
- LANES, default 4: number of lanes, 1..16.
- DW, default 8: bits per lane per cycle; one of 8, 16, 32. SPC = DW/8 symbols per lane per cycle.

Ports:
- clk_1G  in  1: single clock; everything is rising-edge.
- rst_1G  in  1: synchronous, active-high reset.
- en_scram  in  2: mode.
  - 2'b00 and 2'b10: bypass.
  - 2'b01: normal (scramble data blocks only).
  - 2'b11: diagnostic (scramble every block; LFSR advances on all symbols).
- in_valid  in  1: input beat qualifier.
- in_sob  in  1: start of block; marks the beat holding symbol 0 of every lane.
- in_sync  in  2: block sync header, valid with in_sob. 2'b10 = data, 2'b01 = OS.
- in_data  in  LANES*DW: lane n occupies bits [n*DW +: DW]. Symbol 0 is in the low byte; bit 0 is transmitted first.
- out_valid  out  1: registered in_valid.
- out_sob  out  1: registered in_sob.
- out_sync  out  2: registered in_sync (not scrambled).
- out_data  out  LANES*DW: scrambled or bypassed data.
- align_err  out  1: one-cycle pulse; in_sob seen mid-block.

## Operation
Per-lane LFSR:
- 23-bit Galois LFSR, polynomial x^23+x^21+x^16+x^8+x^5+x^2+1.
- Key bit = lfsr[22]. One advance per data bit; DW advances per beat, unrolled combinationally.
- Seed for lane n is SEED[n mod 8]: 1DBFBC, 0607BB, 1EC760, 18C0DB, 010F12, 19CFC9, 0277CE, 1BB807 (hex).

Block tracker:
- Symbol counter 0..15 per block, advancing by SPC per valid beat.
- Block type is latched at in_sob:
  - DATA: in_sync = 10.
  - OS: in_sync = 01, lane-0 symbol 0 any value other than AA or 00.
  - SKP: in_sync = 01, lane-0 symbol 0 = AA.
  - EIEOS: in_sync = 01, lane-0 symbol 0 = 00.
  - Invalid headers 00 and 11 are treated as OS.
- States: UNALIGNED → (valid & in_sob) → IN_BLOCK. Counter wraps 15→0; the next beat must carry in_sob.
- After reset the tracker is UNALIGNED: data passes unscrambled and the LFSRs hold their seed.

Per-type rule, mode 01:

| Block type | Output | LFSR |
|---|---|---|
| DATA | data XOR key | advances |
| OS | clear | advances |
| SKP | clear | holds |
| EIEOS | clear | advances; all lanes reload seed on the beat that completes symbol 15, effective from the next block |

Other modes:
- Mode 11: every block is scrambled and the LFSR always advances. EIEOS reseed still applies.
- Bypass: out_data = in_data and all LFSRs hold their seed. Entering mode 01 or 11 starts from the seed.

Boundary and stall behaviour:
- en_scram is sampled only on valid & in_sob and held for the whole block.
- in_sob while counter ≠ 0: pulse align_err, discard the old block, and start the new block from this beat. LFSR state is kept, not reseeded.
- Missing in_sob at counter 0 while IN_BLOCK: return to UNALIGNED, pass the beat through clear, pulse align_err.
- in_valid low: counter, LFSR, block type and out_data hold; out_valid = 0.

## Timing
- Latency is 1 cycle: input at edge k appears on the outputs after edge k+1.
- No backpressure; one beat is accepted every valid cycle.
- Reset values:
  - out_valid = 0, out_sob = 0, align_err = 0.
  - out_sync = 00, out_data = 0.
  - LFSRs = seeds, tracker = UNALIGNED, counter = 0, latched mode = bypass.
- Reset asserted mid-block overrides everything on that edge. The block in progress is lost with no align_err pulse.
- A block spans 16/SPC valid beats: DW=8 → 16 beats, DW=32 → 4 beats.

## Structure
- Package scram23_pkg holds:
  - LFSR polynomial taps and the SEED[0:7] constant array.
  - Sync-header constants SYNC_DATA and SYNC_OS.
  - OS symbol codes SKP_SYM = 8'hAA and EIEOS_SYM = 8'h00.
  - The block-type enum.
  - Function lfsr_step_n(state, data, n) returning the next state and the scrambled bits.
- One sub-module, scram23_lane (a single lane's LFSR plus XOR), instantiated LANES times with a SEED parameter. The block tracker and mode latch live in the top module and are shared by all lanes.

## Test plan
- Reset, then a mode-01 data block of all-zero data, LANES=4, DW=8 → each lane outputs its seed's keystream, matching the C model byte for byte. Lanes 0 and 3 differ.
- Data block, then SKP block (symbol 0 = AA), then data block → SKP output equals its input exactly. Keystream resumes in the third block exactly where the first block ended.
- EIEOS block (symbol 0 = 00), then data block of zeros → the second block's output equals the post-reset keystream for every lane.
- Mode 00 for the whole run with random data → out_data == in_data delayed by 1 cycle. Switching to 01 at in_sob starts from the seed.
- in_sob at counter 7 → align_err pulses once and the new block is scrambled correctly. in_valid gaps of 1–3 cycles inside a block → output identical to the gapless run.
- DW=32, LANES=9 → 4 beats per block. Lane 8 keystream equals lane 0's. rst_1G at beat 2 → outputs are 0 the next cycle and the tracker returns to UNALIGNED.
